// File: rtl/obi_periph_pkg.sv
// Shared constants for the OBI peripheral target: register word offsets,
// CTRL/STATUS field positions, the default ID value and a byte-merge helper
// used by every byte-maskable register.
package obi_periph_pkg;

    localparam logic [31:0] ID_DEFAULT = 32'h4642_0001;

    // Word offsets, i.e. addr[5:2]
    localparam logic [3:0] OFS_ID      = 4'd0;
    localparam logic [3:0] OFS_CTRL    = 4'd1;
    localparam logic [3:0] OFS_COUNT   = 4'd2;
    localparam logic [3:0] OFS_COMPARE = 4'd3;
    localparam logic [3:0] OFS_STATUS  = 4'd4;
    localparam logic [3:0] OFS_SCR0    = 4'd5;
    localparam logic [3:0] OFS_SCR3    = 4'd8;

    // CTRL fields
    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_PSC_LSB     = 8;
    localparam int CTRL_PSC_MSB     = 15;
    // Implemented CTRL bits; everything else reads 0
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    // STATUS fields
    localparam int STATUS_MATCH = 0;

    // Replace the enabled bytes of old_v with new_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/obi_periph_target_if.sv
// Request/grant/response bus between the CPU_IF tiles and a peripheral.
//   master: drives req, we, be, addr, wdata; receives gnt, rvalid, rdata.
//   slave : the opposite direction.
interface obi_periph_target_if #(
    parameter int ADDR_W = 24
) ();
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_periph_target_timer.sv
// Prescaled 32-bit timer with compare and sticky match flag.
//   enable/auto_reload/prescale : CTRL fields
//   compare                     : COMPARE register (old value used on a tick)
//   cnt_we/cnt_be/cnt_wdata     : bus write to COUNT, overrides a tick
//   match_clr                   : W1C of STATUS.match, loses to a new match
//   psc_restart                 : CTRL write, returns the prescaler to 0
//   count/match                 : current timer value and match flag
module periph_timer
    import obi_periph_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        auto_reload,
    input  logic [7:0]  prescale,
    input  logic [31:0] compare,
    input  logic        cnt_we,
    input  logic [3:0]  cnt_be,
    input  logic [31:0] cnt_wdata,
    input  logic        match_clr,
    input  logic        psc_restart,
    output logic [31:0] count,
    output logic        match
);
    logic [7:0] psc;
    logic       tick;
    logic       hit;

    assign tick = enable && (psc == prescale);
    assign hit  = (count == compare);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc   <= '0;
            count <= '0;
            match <= 1'b0;
        end else begin
            if (psc_restart || !enable || tick)
                psc <= '0;
            else
                psc <= psc + 8'd1;

            // Bus write beats the tick; unwritten bytes keep their old value
            if (cnt_we)
                count <= byte_merge(count, cnt_wdata, cnt_be);
            else if (tick)
                count <= (hit && auto_reload) ? '0 : count + 32'd1;

            // Set has priority over a simultaneous clear
            if (tick && hit)
                match <= 1'b1;
            else if (match_clr)
                match <= 1'b0;
        end
    end
endmodule

// File: rtl/obi_periph_target.sv
// Memory-mapped peripheral target: ID, CTRL, COUNT, COMPARE, STATUS and four
// scratch registers behind a req/gnt/rvalid bus with one-cycle responses.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the peripheral bus (gnt = req, always ready)
//   irq      : registered STATUS.match & CTRL.irq_en
module obi_periph_target
    import obi_periph_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    obi_periph_target_if.slave bus,
    output logic               irq
);
    logic [3:0]       idx;
    logic             wr;
    logic             rd;
    logic [31:0]      ctrl;
    logic [31:0]      compare;
    logic [3:0][31:0] scratch;
    logic             scr_hit;
    logic [1:0]       scr_sel;
    logic [31:0]      count;
    logic             match;
    logic [31:0]      rd_val;
    logic             unused_addr;

    // Only addr[5:2] is decoded; the rest aliases
    assign idx         = bus.addr[5:2];
    assign unused_addr = ^{bus.addr[ADDR_W-1:6], bus.addr[1:0]};

    assign wr      = bus.req && bus.we;
    assign rd      = bus.req && !bus.we;
    assign scr_hit = (idx >= OFS_SCR0) && (idx <= OFS_SCR3);
    assign scr_sel = 2'(idx - OFS_SCR0);

    assign bus.gnt = bus.req;

    periph_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (ctrl[CTRL_ENABLE]),
        .auto_reload (ctrl[CTRL_AUTO_RELOAD]),
        .prescale    (ctrl[CTRL_PSC_MSB:CTRL_PSC_LSB]),
        .compare     (compare),
        .cnt_we      (wr && idx == OFS_COUNT),
        .cnt_be      (bus.be),
        .cnt_wdata   (bus.wdata),
        .match_clr   (wr && idx == OFS_STATUS && bus.be[0] && bus.wdata[STATUS_MATCH]),
        .psc_restart (wr && idx == OFS_CTRL),
        .count       (count),
        .match       (match)
    );

    // Read mux sees register contents before this cycle's updates
    always_comb begin
        rd_val = '0;
        if (scr_hit)
            rd_val = scratch[scr_sel];
        else begin
            case (idx)
                OFS_ID:      rd_val = ID_VALUE;
                OFS_CTRL:    rd_val = ctrl;
                OFS_COUNT:   rd_val = count;
                OFS_COMPARE: rd_val = compare;
                OFS_STATUS:  rd_val = {31'd0, match};
                default:     rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl       <= '0;
            compare    <= '0;
            scratch    <= '0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            irq        <= 1'b0;
        end else begin
            bus.rvalid <= bus.req;
            bus.rdata  <= rd ? rd_val : '0;
            irq        <= match && ctrl[CTRL_IRQ_EN];
            if (wr && idx == OFS_CTRL)
                ctrl <= byte_merge(ctrl, bus.wdata, bus.be) & CTRL_MASK;
            if (wr && idx == OFS_COMPARE)
                compare <= byte_merge(compare, bus.wdata, bus.be);
            if (wr && scr_hit)
                scratch[scr_sel] <= byte_merge(scratch[scr_sel], bus.wdata, bus.be);
        end
    end
endmodule

// File: tb/tb_obi_periph_target.sv
// Bench for obi_periph_target: directed steps plus a random phase, every
// cycle compared against a register-level reference model.
module tb_obi_periph_target;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    always #5 clk = ~clk;

    obi_periph_target_if #(.ADDR_W(24)) bus ();
    obi_periph_target #(.ADDR_W(24)) dut (.clk(clk), .rst(rst), .bus(bus), .irq(irq));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_ctrl, m_count, m_cmp;
    logic [31:0] m_scr [4];
    logic        m_match;
    int          m_psc;
    logic        e_rvalid, e_irq;
    logic [31:0] e_rdata;
    logic        last_rvalid;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = b[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int w);
        if (w == 0) return 32'h4642_0001;
        if (w == 1) return m_ctrl;
        if (w == 2) return m_count;
        if (w == 3) return m_cmp;
        if (w == 4) return {31'd0, m_match};
        if (w >= 5 && w <= 8) return m_scr[w-5];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_psc = 0;
        for (int i = 0; i < 4; i++) m_scr[i] = 0;
        e_rvalid = 0; e_rdata = 0; e_irq = 0;
    endtask

    // One clock edge of the whole peripheral, from the register-map rules
    task automatic model_edge(input logic r, input logic w, input logic [3:0] b,
                              input logic [23:0] a, input logic [31:0] d);
        int          wi;
        bit          tick, newmatch;
        logic [31:0] old_count;
        if (rst) begin model_reset(); return; end
        wi        = int'(a[5:2]);
        e_rvalid  = r;
        e_rdata   = (r && !w) ? m_read(wi) : 32'd0;
        e_irq     = m_match & m_ctrl[2];
        old_count = m_count;
        tick      = m_ctrl[0] && (m_psc == int'(m_ctrl[15:8]));
        newmatch  = tick && (m_count == m_cmp);
        if (tick) begin
            m_psc = 0;
            if (newmatch && m_ctrl[1]) m_count = 0;
            else m_count = m_count + 1;
        end else if (m_ctrl[0]) m_psc = m_psc + 1;
        else m_psc = 0;
        if (newmatch) m_match = 1;
        if (r && w) begin
            case (wi)
                1: begin m_ctrl = merge(m_ctrl, d, b) & 32'h0000_FF07; m_psc = 0; end
                2: m_count = merge(old_count, d, b);
                3: m_cmp = merge(m_cmp, d, b);
                4: if (b[0] && d[0] && !newmatch) m_match = 0;
                5, 6, 7, 8: m_scr[wi-5] = merge(m_scr[wi-5], d, b);
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [23:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req = r; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
        #1 check("gnt", 32'(bus.gnt), 32'(r));
        @(posedge clk);
        model_edge(r, w, b, a, d);
        #1;
        last_rvalid = bus.rvalid;
        last_rdata  = bus.rdata;
        check("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
        check("rdata", bus.rdata, e_rdata);
        check("irq", 32'(irq), 32'(e_irq));
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b1, 1'b1, b, a, d);
    endtask
    task automatic rdr(input logic [23:0] a);
        step(1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] rnd, d;
        logic [23:0] a;
        bit          seen;
        bus.req = 0; bus.we = 0; bus.be = 0; bus.addr = 0; bus.wdata = 0;
        model_reset();
        idle(); idle();
        @(negedge clk) rst = 1'b0;

        // Reset state
        idle();
        check("reset_rvalid", 32'(bus.rvalid), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);

        // ID and alias
        rdr(24'h000000); check("id", last_rdata, 32'h4642_0001);
        rdr(24'h000040); check("id_alias", last_rdata, 32'h4642_0001);

        // Byte enables with four back-to-back transactions
        wr(24'h000018, 32'hDEAD_BEEF, 4'hF); check("b2b_0", 32'(last_rvalid), 32'd1);
        wr(24'h000018, 32'h0000_0055, 4'h1); check("b2b_1", 32'(last_rvalid), 32'd1);
        rdr(24'h000018);                     check("b2b_2", 32'(last_rvalid), 32'd1);
        check("scr1_be", last_rdata, 32'hDEAD_BE55);
        rdr(24'h000000);                     check("b2b_3", 32'(last_rvalid), 32'd1);

        // be=0 write and unmapped space
        wr(24'h000014, 32'h1234_5678, 4'h0); rdr(24'h000014); check("be0", last_rdata, 32'd0);
        wr(24'h000024, 32'hFFFF_FFFF, 4'hF); rdr(24'h000024); check("unmapped", last_rdata, 32'd0);

        // Timer with auto-reload
        wr(24'h00000C, 32'd3, 4'hF);
        wr(24'h000004, 32'h0000_0107, 4'hF);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rdr(24'h000008);
            seen = irq;
        end
        check("irq_rise", 32'(irq), 32'd1);
        wr(24'h000010, 32'd1, 4'h1);
        idle();
        check("irq_clear", 32'(irq), 32'd0);
        wr(24'h000004, 32'd0, 4'hF);
        wr(24'h000010, 32'd1, 4'h1);

        // Wrap does not match
        wr(24'h000008, 32'hFFFF_FFFF, 4'hF);
        wr(24'h00000C, 32'd5, 4'hF);
        wr(24'h000004, 32'h0000_0001, 4'hF);
        rdr(24'h000008); check("wrap_pre", last_rdata, 32'hFFFF_FFFF);
        rdr(24'h000008); check("wrap_zero", last_rdata, 32'd0);
        rdr(24'h000010); check("wrap_nomatch", last_rdata, 32'd0);

        // Simultaneous events (prescale 0 ticks every cycle)
        wr(24'h000008, 32'h100, 4'hF);
        rdr(24'h000008); check("count_wr_wins", last_rdata, 32'h100);
        wr(24'h000008, 32'h200, 4'hF);
        wr(24'h00000C, 32'h201, 4'hF);
        wr(24'h000010, 32'd1, 4'h1);
        rdr(24'h000010); check("set_beats_clr", last_rdata, 32'd1);
        wr(24'h000004, 32'd0, 4'hF);
        wr(24'h000010, 32'd1, 4'h1);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            rnd = $urandom;
            a   = 24'($urandom);
            d   = $urandom;
            if (a[5:2] == 4'd1) d[15:8] = 8'($urandom_range(0, 3));
            if (a[5:2] == 4'd2 || a[5:2] == 4'd3) d = $urandom_range(0, 20);
            step(rnd[1:0] != 2'b00, rnd[2], rnd[7:4], a, d);
        end

        // Reset while a read response is pending
        wr(24'h00001C, 32'hCAFE_F00D, 4'hF);
        wr(24'h000004, 32'h0000_0005, 4'hF);
        @(negedge clk);
        bus.req = 1; bus.we = 0; bus.be = 0; bus.addr = 24'h00001C; bus.wdata = 0;
        @(posedge clk);
        rst = 1'b1;
        model_reset();
        #1 check("rst_drop", 32'(bus.rvalid), 32'd0);
        idle(); idle();
        @(negedge clk) rst = 1'b0;
        idle();
        check("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
        for (int i = 0; i < 16; i++) rdr(24'(i * 4));
        rdr(24'h00001C); check("post_rst_scr", last_rdata, 32'd0);
        rdr(24'h000008); check("post_rst_count", last_rdata, 32'd0);
        rdr(24'h000004); check("post_rst_ctrl", last_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
